elevator_dispatch_scheduler: RTL

Request scheduler and door sequencer for the 4-floor car datapath. It latches floor-button requests into a pending set and picks the next target floor using a LOOK policy: keep the current direction while requests lie ahead, otherwise reverse. It issues one move command at a time to the car over a valid/ready handshake and times the door-open interval on arrival. It sits between the button inputs and the car motion block.

---
 rtl/elevator_dispatch_scheduler.sv | 137 +++++++++++++
 1 files changed

// File: rtl/elevator_dispatch_scheduler.sv
// LOOK-policy request scheduler and door sequencer for a 4-floor car.
// Issues one move command at a time over valid/ready and times the door on arrival.
module elevator_dispatch_scheduler #(
  parameter int DOOR_CYCLES = 8,
  parameter int NUM_FLOORS  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic [1:0] car_floor,
  input  logic       cmd_ready,
  input  logic       arrive,
  output logic       cmd_valid,
  output logic [1:0] cmd_floor,
  output logic [3:0] pending,
  output logic       dir_up,
  output logic       door_open,
  output logic       busy
);

  // state | meaning
  // IDLE  | no command out, door closed; picks next stop from pending
  // ISSUE | cmd_valid held with a stable cmd_floor until cmd_ready
  // MOVE  | command accepted, waiting for the arrive strobe
  // DOOR  | door open, counting down; re-press at this floor reloads
  typedef enum logic [1:0] {IDLE, ISSUE, MOVE, DOOR} state_t;

  localparam int CW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(DOOR_CYCLES - 1);

  state_t                state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic                  cmd_valid_n, dir_up_n, door_open_n;
  logic [1:0]            cmd_floor_n;
  logic [NUM_FLOORS-1:0] here, clr, ahead_up, ahead_dn, pending_n;

  function automatic logic [1:0] lowest(input logic [3:0] v);
    lowest = 2'd0;
    for (int i = 3; i >= 0; i--) if (v[i]) lowest = 2'(i);
  endfunction

  function automatic logic [1:0] highest(input logic [3:0] v);
    highest = 2'd0;
    for (int i = 0; i < 4; i++) if (v[i]) highest = 2'(i);
  endfunction

  assign here     = 4'b0001 << car_floor;
  assign ahead_up = pending & (4'b1110 << car_floor);
  assign ahead_dn = pending & (here - 4'b0001);
  assign busy     = (state != IDLE);

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    cmd_valid_n = cmd_valid;
    cmd_floor_n = cmd_floor;
    dir_up_n    = dir_up;
    door_open_n = door_open;
    clr         = '0;
    case (state)
      IDLE: begin
        if (|(pending & here)) begin
          clr         = here;
          door_open_n = 1'b1;
          cnt_n       = CNT_LOAD;
          state_n     = DOOR;
        end else if (|pending) begin
          cmd_valid_n = 1'b1;
          state_n     = ISSUE;
          // Keep sweeping while something lies ahead, otherwise reverse
          if (dir_up) begin
            if (|ahead_up) cmd_floor_n = lowest(ahead_up);
            else begin
              dir_up_n    = 1'b0;
              cmd_floor_n = highest(ahead_dn);
            end
          end else begin
            if (|ahead_dn) cmd_floor_n = highest(ahead_dn);
            else begin
              dir_up_n    = 1'b1;
              cmd_floor_n = lowest(ahead_up);
            end
          end
        end
      end
      ISSUE: begin
        if (cmd_ready) begin
          cmd_valid_n = 1'b0;
          state_n     = MOVE;
        end
      end
      MOVE: begin
        if (arrive) begin
          clr         = here;
          door_open_n = 1'b1;
          cnt_n       = CNT_LOAD;
          state_n     = DOOR;
        end
      end
      DOOR: begin
        if (|(req & here)) begin
          clr   = here;
          cnt_n = CNT_LOAD;
        end else if (cnt == '0) begin
          door_open_n = 1'b0;
          state_n     = IDLE;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    // Servicing a floor beats a same-cycle press of that floor
    pending_n = (pending | req) & ~clr;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      pending   <= '0;
      cmd_valid <= 1'b0;
      cmd_floor <= 2'd0;
      dir_up    <= 1'b1;
      door_open <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      pending   <= pending_n;
      cmd_valid <= cmd_valid_n;
      cmd_floor <= cmd_floor_n;
      dir_up    <= dir_up_n;
      door_open <= door_open_n;
    end
  end

endmodule
